// File: rtl/stall_ctrl.sv
// Purpose : stall/flush scheduler for the 5-stage core; drives hold/bubble controls for PC,
//           IF/ID, ID/EX, EX/MEM, MEM/WB and owns the divide busy counter and a stall-cycle counter.
// Latency : control outputs are combinational from registered state/counter and current inputs.
// Backpr. : stalls the front of the pipe on load-use, divide and data-memory wait states;
//           memory wait states override every other pattern.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   rs1_ifr_i, rs2_ifr_i  source registers of the instruction in IF/ID
//   rd_idr_i              destination register of the instruction in ID/EX
//   MemRead_idr_i         ID/EX holds a load
//   div_idr_i             ID/EX holds a divide/remainder
//   branch_taken_i        ID/EX resolved a taken branch/jump
//   mem_req_exr_i         EX/MEM accesses data memory
//   mem_ack_i             data memory completes the access this cycle
//   stall_pc_o            hold PC
//   stall_r_o[3:0]        hold pipeline register (bit0 IF/ID .. bit3 MEM/WB)
//   flush_r_o[3:0]        load a bubble into pipeline register, same bit map
//   div_done_o            divider result valid in EX this cycle
//   busy_o                divide in progress (DIV_WAIT)
//   stall_cycles_o        free-running count of cycles with stall_pc_o=1
module stall_ctrl #(
    parameter int DIV_LAT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_ifr_i,
    input  logic [4:0]  rs2_ifr_i,
    input  logic [4:0]  rd_idr_i,
    input  logic        MemRead_idr_i,
    input  logic        div_idr_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_exr_i,
    input  logic        mem_ack_i,
    output logic        stall_pc_o,
    output logic [3:0]  stall_r_o,
    output logic [3:0]  flush_r_o,
    output logic        div_done_o,
    output logic        busy_o,
    output logic [31:0] stall_cycles_o
);

    localparam int CW = $clog2(DIV_LAT);
    // The detect cycle is spent in RUN and the release cycle at cnt==0,
    // so the counter only has to cover the DIV_LAT-2 cycles in between.
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT - 2);

    // Control patterns {stall_pc, stall_r, flush_r}
    localparam logic [8:0] PAT_NONE   = {1'b0, 4'b0000, 4'b0000};
    localparam logic [8:0] PAT_MEM    = {1'b1, 4'b0111, 4'b1000};
    localparam logic [8:0] PAT_BRANCH = {1'b0, 4'b0000, 4'b0011};
    localparam logic [8:0] PAT_DIV    = {1'b1, 4'b0011, 4'b0100};
    localparam logic [8:0] PAT_LDUSE  = {1'b1, 4'b0001, 4'b0010};

    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    stall_cycles_q;

    logic           memstall;
    logic           loaduse;
    logic [8:0]     pat;
    logic           div_done;

    assign memstall = mem_req_exr_i & ~mem_ack_i;
    assign loaduse  = MemRead_idr_i & (rd_idr_i != 5'd0) &
                      ((rd_idr_i == rs1_ifr_i) | (rd_idr_i == rs2_ifr_i));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat      = PAT_NONE;
        div_done = 1'b0;

        case (state_q)
            RUN: begin
                if (memstall) begin
                    pat = PAT_MEM;
                end else if (branch_taken_i) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed;
                    // a divide or load-use in the shadow of the branch is dead.
                    pat = PAT_BRANCH;
                end else if (div_idr_i) begin
                    pat     = PAT_DIV;
                    cnt_d   = CNT_INIT;
                    state_d = DIV_WAIT;
                end else if (loaduse) begin
                    pat = PAT_LDUSE;
                end
            end

            DIV_WAIT: begin
                // The divider keeps working through memory wait states,
                // so the countdown is not gated by memstall.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end

                if (memstall) begin
                    // Release is deferred while cnt sits at 0.
                    pat = PAT_MEM;
                end else if (cnt_q != '0) begin
                    pat = PAT_DIV;
                end else begin
                    // ID/EX advances here, so the divide is not seen again in RUN.
                    div_done = 1'b1;
                    state_d  = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are suppressed during reset so nothing in the pipe moves on stale state.
    assign stall_pc_o     = ~rst_i & pat[8];
    assign stall_r_o      = rst_i ? 4'b0000 : pat[7:4];
    assign flush_r_o      = rst_i ? 4'b0000 : pat[3:0];
    assign div_done_o     = ~rst_i & div_done;
    assign busy_o         = (state_q == DIV_WAIT);
    assign stall_cycles_o = stall_cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_pc_o) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Purpose : directed checks of stall_ctrl with DIV_LAT=4; driver queues expectations, monitor checks.
// Latency : driver applies one vector per cycle just after the rising edge; monitor samples on the falling edge.
// Backpr. : none; the driver waits a bounded number of cycles for the monitor to drain the queue.
module tb_stall_ctrl;

    logic        clk;
    logic        rst_i;
    logic [4:0]  rs1_ifr_i, rs2_ifr_i, rd_idr_i;
    logic        MemRead_idr_i, div_idr_i, branch_taken_i, mem_req_exr_i, mem_ack_i;
    logic        stall_pc_o;
    logic [3:0]  stall_r_o, flush_r_o;
    logic        div_done_o, busy_o;
    logic [31:0] stall_cycles_o;

    stall_ctrl #(.DIV_LAT(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .rs1_ifr_i      (rs1_ifr_i),
        .rs2_ifr_i      (rs2_ifr_i),
        .rd_idr_i       (rd_idr_i),
        .MemRead_idr_i  (MemRead_idr_i),
        .div_idr_i      (div_idr_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_exr_i  (mem_req_exr_i),
        .mem_ack_i      (mem_ack_i),
        .stall_pc_o     (stall_pc_o),
        .stall_r_o      (stall_r_o),
        .flush_r_o      (flush_r_o),
        .div_done_o     (div_done_o),
        .busy_o         (busy_o),
        .stall_cycles_o (stall_cycles_o)
    );

    typedef struct packed {
        logic        spc;
        logic [3:0]  sr;
        logic [3:0]  fr;
        logic        dd;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_sc = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a control word; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_pc",     {31'd0, stall_pc_o}, {31'd0, e.spc});
                chk("stall_r",      {28'd0, stall_r_o},  {28'd0, e.sr});
                chk("flush_r",      {28'd0, flush_r_o},  {28'd0, e.fr});
                chk("div_done",     {31'd0, div_done_o}, {31'd0, e.dd});
                chk("busy",         {31'd0, busy_o},     {31'd0, e.busy});
                chk("stall_cycles", stall_cycles_o,      e.sc);
            end
        end
    end

    // One pipeline cycle: drive inputs, queue the hand-computed response.
    task automatic vec(input logic r, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic mr, input logic dv, input logic br, input logic mq, input logic ma,
                       input logic e_spc, input logic [3:0] e_sr, input logic [3:0] e_fr,
                       input logic e_dd, input logic e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = r; rs1_ifr_i = a; rs2_ifr_i = b; rd_idr_i = d;
        MemRead_idr_i = mr; div_idr_i = dv; branch_taken_i = br;
        mem_req_exr_i = mq; mem_ack_i = ma;
        e.spc = e_spc; e.sr = e_sr; e.fr = e_fr; e.dd = e_dd; e.busy = e_busy; e.sc = exp_sc;
        sb.push_back(e);
        if (r)          exp_sc = 32'd0;
        else if (e_spc) exp_sc = exp_sc + 32'd1;
    endtask

    initial begin
        rst_i = 1'b1; rs1_ifr_i = '0; rs2_ifr_i = '0; rd_idr_i = '0;
        MemRead_idr_i = 0; div_idr_i = 0; branch_taken_i = 0; mem_req_exr_i = 0; mem_ack_i = 0;

        //   rst rs1 rs2 rd  mr dv br mq ma | spc sr       fr       dd busy
        // Reset: outputs forced low even with every hazard present
        vec(1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        vec(1, 5, 5, 5,  1, 1, 1, 1, 0,  0, 4'b0000, 4'b0000, 0, 0);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // Load-use on rs2, exactly one cycle
        vec(0, 1, 5, 5,  1, 0, 0, 0, 0,  1, 4'b0001, 4'b0010, 0, 0);
        vec(0, 1, 6, 5,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // rd=x0 never hazards
        vec(0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // Load-use on rs1, then non-matching load
        vec(0, 7, 3, 7,  1, 0, 0, 0, 0,  1, 4'b0001, 4'b0010, 0, 0);
        vec(0, 7, 3, 8,  1, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // Divide T0..T3; branch/load-use ignored in DIV_WAIT
        vec(0, 0, 0, 0,  0, 1, 0, 0, 0,  1, 4'b0011, 4'b0100, 0, 0);
        vec(0, 5, 0, 5,  1, 1, 1, 0, 0,  1, 4'b0011, 4'b0100, 0, 1);
        vec(0, 0, 0, 0,  0, 1, 0, 0, 0,  1, 4'b0011, 4'b0100, 0, 1);
        vec(0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 4'b0000, 4'b0000, 1, 1);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // Divide overlapped by memory wait T2..T4, release at T5
        vec(0, 0, 0, 0,  0, 1, 0, 0, 0,  1, 4'b0011, 4'b0100, 0, 0);
        vec(0, 0, 0, 0,  0, 1, 0, 0, 0,  1, 4'b0011, 4'b0100, 0, 1);
        vec(0, 0, 0, 0,  0, 1, 0, 1, 0,  1, 4'b0111, 4'b1000, 0, 1);
        vec(0, 0, 0, 0,  0, 1, 0, 1, 0,  1, 4'b0111, 4'b1000, 0, 1);
        vec(0, 0, 0, 0,  0, 1, 0, 1, 0,  1, 4'b0111, 4'b1000, 0, 1);
        vec(0, 0, 0, 0,  0, 1, 0, 1, 1,  0, 4'b0000, 4'b0000, 1, 1);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // Branch beats load-use and divide; divide is dropped
        vec(0, 5, 0, 5,  1, 0, 1, 0, 0,  0, 4'b0000, 4'b0011, 0, 0);
        vec(0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 4'b0000, 4'b0011, 0, 0);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // Branch under memstall, zero-wait access, divide under memstall stays in RUN
        vec(0, 0, 0, 0,  0, 0, 1, 1, 0,  1, 4'b0111, 4'b1000, 0, 0);
        vec(0, 0, 0, 0,  0, 0, 0, 1, 1,  0, 4'b0000, 4'b0000, 0, 0);
        vec(0, 0, 0, 0,  0, 1, 0, 1, 0,  1, 4'b0111, 4'b1000, 0, 0);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // Reset at T1 of a divide
        vec(0, 0, 0, 0,  0, 1, 0, 0, 0,  1, 4'b0011, 4'b0100, 0, 0);
        vec(1, 0, 0, 0,  0, 1, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 1);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);

        // Counter wrap: preload all-ones after this cycle's sample, then one load-use stall
        @(negedge clk);
        #2;
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        exp_sc = 32'hFFFF_FFFF;
        vec(0, 9, 2, 9,  1, 0, 0, 0, 0,  1, 4'b0001, 4'b0010, 0, 0);
        vec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain act=%0d exp=0 pending entries", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
